// File: rtl/e203_exu_longp_oitf.sv
// Outstanding Instruction Track FIFO for the EXU long pipe.
// Optional feature macro: E203_OITF_RDFPU_EN (FP-destination tracking + rs3 match).
// Each slot is an e203_exu_longp_oitf_entry instance that holds its payload
// and does its own register compares; the top keeps the two wrap-flagged pointers.

`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 1
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

// One OITF slot: payload registers plus per-query destination compares.
module e203_exu_longp_oitf_entry #(
  parameter int RFW = 5,
  parameter int PCW = 32,
  parameter int NQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_i,
  input  logic                    clr_i,
  input  logic [RFW-1:0]          rdidx_i,
  input  logic                    rdwen_i,
  input  logic                    rdfpu_i,
  input  logic [PCW-1:0]          pc_i,
  input  logic [NQ-1:0][RFW-1:0]  q_idx_i,
  input  logic [NQ-1:0]           q_fpu_i,
  output logic [RFW-1:0]          rdidx_o,
  output logic                    rdwen_o,
  output logic                    rdfpu_o,
  output logic [PCW-1:0]          pc_o,
  output logic [NQ-1:0]           hit_o
);
  logic           vld_q;
  logic [RFW-1:0] rdidx_q;
  logic           rdwen_q;
  logic [PCW-1:0] pc_q;

  // Valid bit: set on alloc, cleared on retire (alloc wins, never both in practice).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_q <= 1'b0;
    else if (set_i) vld_q <= 1'b1;
    else if (clr_i) vld_q <= 1'b0;
  end

  // Payload captured on alloc; left stale after retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdidx_q <= '0;
      rdwen_q <= 1'b0;
      pc_q    <= '0;
    end else if (set_i) begin
      rdidx_q <= rdidx_i;
      rdwen_q <= rdwen_i;
      pc_q    <= pc_i;
    end
  end

  assign rdidx_o = rdidx_q;
  assign rdwen_o = rdwen_q;
  assign pc_o    = pc_q;

`ifdef E203_OITF_RDFPU_EN
  logic rdfpu_q;

  // FP-destination flag, stored only when FP tracking is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdfpu_q <= 1'b0;
    else if (set_i) rdfpu_q <= rdfpu_i;
  end

  assign rdfpu_o = rdfpu_q;

  for (genvar q = 0; q < NQ; q++) begin : g_hit
    assign hit_o[q] = vld_q & rdwen_q & (rdidx_q == q_idx_i[q]) & (rdfpu_q == q_fpu_i[q]);
  end
`else
  logic unused_fpu;
  assign unused_fpu = ^{rdfpu_i, q_fpu_i};
  assign rdfpu_o    = 1'b0;

  for (genvar q = 0; q < NQ; q++) begin : g_hit
    assign hit_o[q] = vld_q & rdwen_q & (rdidx_q == q_idx_i[q]);
  end
`endif
endmodule

module e203_exu_longp_oitf #(
  parameter int DEPTH = 2,
  parameter int PTRW  = `E203_ITAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dis_ena,
  output logic                         dis_ready,
  output logic [PTRW-1:0]              dis_ptr,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic                         disp_i_rdwen,
  input  logic                         disp_i_rdfpu,
  input  logic [`E203_PC_SIZE-1:0]     disp_i_pc,
  input  logic                         ret_ena,
  output logic [PTRW-1:0]              ret_ptr,
  output logic [`E203_RFIDX_WIDTH-1:0] ret_rdidx,
  output logic                         ret_rdwen,
  output logic                         ret_rdfpu,
  output logic [`E203_PC_SIZE-1:0]     ret_pc,
  output logic                         oitf_empty,
  input  logic                         disp_i_rs1en,
  input  logic                         disp_i_rs2en,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic                         disp_i_rs1fpu,
  input  logic                         disp_i_rs2fpu,
`ifdef E203_OITF_RDFPU_EN
  input  logic                         disp_i_rs3en,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs3idx,
  output logic                         oitfrd_match_disprs3,
`endif
  output logic                         oitfrd_match_disprs1,
  output logic                         oitfrd_match_disprs2,
  output logic                         oitfrd_match_disprd
);
  localparam int RFW = `E203_RFIDX_WIDTH;
  localparam int PCW = `E203_PC_SIZE;
  // Query slots: 0=rs1, 1=rs2, 2=rd, 3=rs3 (FP build only).
`ifdef E203_OITF_RDFPU_EN
  localparam int NQ = 4;
`else
  localparam int NQ = 3;
`endif

  logic [PTRW:0] alc_q, alc_d;
  logic [PTRW:0] ret_q, ret_d;
  logic          empty, full, alc_fire, ret_fire;

  assign empty     = (alc_q == ret_q);
  assign full      = (alc_q[PTRW-1:0] == ret_q[PTRW-1:0]) & (alc_q[PTRW] != ret_q[PTRW]);
  assign alc_fire  = dis_ena & ~full;
  assign ret_fire  = ret_ena & ~empty;
  // Power-of-two depth: carry out of the index naturally toggles the wrap flag.
  assign alc_d     = alc_q + (PTRW+1)'(alc_fire);
  assign ret_d     = ret_q + (PTRW+1)'(ret_fire);

  assign dis_ready  = ~full;
  assign oitf_empty = empty;
  assign dis_ptr    = alc_q[PTRW-1:0];
  assign ret_ptr    = ret_q[PTRW-1:0];

  // Alloc and retire pointers with wrap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alc_q <= '0;
      ret_q <= '0;
    end else begin
      alc_q <= alc_d;
      ret_q <= ret_d;
    end
  end

  logic [NQ-1:0][RFW-1:0]    q_idx;
  logic [NQ-1:0]             q_fpu;
  logic [DEPTH-1:0][RFW-1:0] e_rdidx;
  logic [DEPTH-1:0]          e_rdwen;
  logic [DEPTH-1:0]          e_rdfpu;
  logic [DEPTH-1:0][PCW-1:0] e_pc;
  logic [DEPTH-1:0][NQ-1:0]  e_hit;
  logic [NQ-1:0]             hit_any;

  assign q_idx[0] = disp_i_rs1idx;
  assign q_idx[1] = disp_i_rs2idx;
  assign q_idx[2] = disp_i_rdidx;
  assign q_fpu[0] = disp_i_rs1fpu;
  assign q_fpu[1] = disp_i_rs2fpu;
  assign q_fpu[2] = disp_i_rdfpu;
`ifdef E203_OITF_RDFPU_EN
  // rs3 only exists for FP fused ops, so it always names an FP register.
  assign q_idx[3] = disp_i_rs3idx;
  assign q_fpu[3] = 1'b1;
`endif

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    e203_exu_longp_oitf_entry #(.RFW(RFW), .PCW(PCW), .NQ(NQ)) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_i   (alc_fire & (alc_q[PTRW-1:0] == PTRW'(e))),
      .clr_i   (ret_fire & (ret_q[PTRW-1:0] == PTRW'(e))),
      .rdidx_i (disp_i_rdidx),
      .rdwen_i (disp_i_rdwen),
      .rdfpu_i (disp_i_rdfpu),
      .pc_i    (disp_i_pc),
      .q_idx_i (q_idx),
      .q_fpu_i (q_fpu),
      .rdidx_o (e_rdidx[e]),
      .rdwen_o (e_rdwen[e]),
      .rdfpu_o (e_rdfpu[e]),
      .pc_o    (e_pc[e]),
      .hit_o   (e_hit[e])
    );
  end

  // OR-reduce per-entry hits for each query.
  always_comb begin
    hit_any = '0;
    for (int e = 0; e < DEPTH; e++) hit_any |= e_hit[e];
  end

  assign ret_rdidx = e_rdidx[ret_q[PTRW-1:0]];
  assign ret_rdwen = e_rdwen[ret_q[PTRW-1:0]];
  assign ret_rdfpu = e_rdfpu[ret_q[PTRW-1:0]];
  assign ret_pc    = e_pc[ret_q[PTRW-1:0]];

  assign oitfrd_match_disprs1 = disp_i_rs1en & hit_any[0];
  assign oitfrd_match_disprs2 = disp_i_rs2en & hit_any[1];
  assign oitfrd_match_disprd  = disp_i_rdwen & hit_any[2];
`ifdef E203_OITF_RDFPU_EN
  assign oitfrd_match_disprs3 = disp_i_rs3en & hit_any[3];
`endif
endmodule
